dut_in_fifo: RTL and testbench
==============================

# dut_in_fifo

- Ingress buffer in front of the `dut_top` datapath: decouples the bench-driven input stream from the core's consumption rate.
- Accepts 16-bit words on a valid/ready interface and stores them in order in a DEPTH-entry buffer.
- Presents words first-word-fall-through on a registered output valid/ready interface.
- Reports fill level and a high-water mark for coverage and debug.

## Interface
- `DW`, 16, data width in bits (matches the signed 16-bit stimulus words).
- `DEPTH`, 16, entry count; power of two, 2 to 256.
- `AW`, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  synchronous clear of contents; takes priority over all traffic in the same cycle.
- `in_valid`  in  1  upstream word present.
- `in_data`  in  DW  upstream word.
- `in_ready`  out  1  buffer can accept a word this cycle.
- `out_valid`  out  1  `out_data` holds the oldest stored word.
- `out_data`  out  DW  head word, registered.
- `out_ready`  in  1  downstream takes the word this cycle.
- `level`  out  AW+1  words currently held, including the output register.
- `hwm`  out  AW+1  maximum `level` seen since reset or flush.

## Operation
- Write occurs when `in_valid && in_ready`. Read occurs when `out_valid && out_ready`.
- Storage consists of a RAM array plus a one-word output register. `level` counts both, up to DEPTH in total.
- `in_ready = !(level == DEPTH)`. It does not depend on `out_ready`, so no combinational path runs from output to input.
- Behaviour while full: a simultaneous read does not allow a same-cycle write. `in_ready` rises on the cycle after the read.
- Output register refill: when the register is empty, or is being read, it loads the next word.
  - Source is the array if the array is non-empty.
  - Otherwise it loads the word written this cycle.
- Order is strict FIFO. No word is duplicated or dropped.
- `level` next value = `level` + write − read.
- `hwm` next value = max(`hwm`, next `level`).
- Pointers use AW bits and wrap modulo DEPTH with no special handling.
- When `flush` = 1:
  - Next cycle: `level` = 0, `hwm` = 0, `out_valid` = 0, pointers = 0.
  - Any write or read in the flush cycle is discarded.
- Reset (asynchronous, any time, including mid-transfer) sets:
  - `out_valid` = 0, `out_data` = 0, `level` = 0, `hwm` = 0, pointers = 0.
  - `in_ready` = 0 while `rst_n` is low.
- The array is not reset.

## Timing
- `in_ready` goes to 1 at the first `clk` rising edge after `rst_n` deasserts.
- Latency, write into an empty FIFO to `out_valid`: 1 cycle. A word accepted at edge N is visible on `out_data` after edge N.
- Sustained throughput: 1 word per cycle in and out whenever neither side stalls.
- `out_data`/`out_valid` are held stable while `out_valid && !out_ready`.
- Upstream must hold `in_data` stable while `in_valid && !in_ready`. The bench asserts this requirement.

## Configuration
- Macro: `DUT_IN_FIFO_BYPASS_EN`.
- Defined:
  - When `level` == 0 and `in_valid` = 1, `out_valid` and `out_data` are driven combinationally from the input.
  - If `out_ready` = 1 in that cycle, the word passes through with 0-cycle latency and `level` is unchanged.
  - Otherwise the word is captured normally.
  - `in_ready` is unchanged.
- Not defined: the output is purely registered with the 1-cycle latency stated above. This is the default build.

## Test plan
- Reset then single word:
  - Release `rst_n`, write 0xFF89 at cycle 2 with `out_ready` = 1.
  - `out_valid` = 1 with 0xFF89 at cycle 3, `level` 1 → 0, `hwm` = 1.
- Fill to full:
  - Write 16 words 0x0000–0x000F with `out_ready` = 0.
  - `in_ready` = 0 after the 16th write, `level` = 16, `hwm` = 16.
  - A 17th `in_valid` is not accepted. Drain returns 0x0000–0x000F in order.
- Wrap and simultaneous traffic:
  - Stream 40 words 0x0089+i with `out_ready` toggling 1,1,0.
  - All 40 words arrive in order, `level` never exceeds 16, pointers wrap at least twice.
- Full-with-read:
  - At `level` 16, assert `out_ready` and `in_valid` together.
  - The read occurs and the write is refused. `in_ready` = 1 the next cycle, and `level` = 15.
- Flush and reset mid-operation:
  - At `level` 7, pulse `flush` alongside a write.
    - Next cycle `level` = 0, `hwm` = 0, `out_valid` = 0, and the flushed-cycle word never appears.
  - Repeat with `rst_n` low mid-cycle.
    - Outputs clear immediately without waiting for a clock edge.
- Bypass build (`DUT_IN_FIFO_BYPASS_EN` defined), empty FIFO:
  - Write 0x1234 with `out_ready` = 1.
  - `out_valid` = 1 with 0x1234 in the same cycle, and `level` stays 0.

Source files
------------

// File: rtl/dut_in_fifo.sv
// dut_in_fifo -- ingress buffer in front of the dut_top datapath.
//
// Stores DW-bit words in strict FIFO order in a RAM array backed by a
// one-word registered output stage (first-word-fall-through). Reports the
// current fill level and a high-water mark.
//
// Ports:
//   clk        single clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear, overrides all traffic in the same cycle
//   in_valid   upstream word present
//   in_data    upstream word
//   in_ready   buffer can accept a word (independent of out_ready)
//   out_valid  out_data holds the oldest stored word
//   out_data   head word
//   out_ready  downstream takes the word this cycle
//   level      words held, array plus output register
//   hwm        maximum level since reset or flush
//
// Optional feature macro: DUT_IN_FIFO_BYPASS_EN
//   When defined, an empty FIFO presents the incoming word combinationally
//   on the output; if it is taken in that same cycle it is never stored.
module dut_in_fifo #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic [AW:0]   hwm
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [AW:0]   hwm_reg;
  logic          out_valid_reg;
  logic [DW-1:0] out_data_reg;
  // Holds in_ready low until the first clock edge after reset release.
  logic          init_reg;

  logic [AW:0]   arr_count;
  logic [AW:0]   level_next;
  logic          wr;
  logic          rd;
  logic          store;
  logic          reg_load;
  logic          from_arr;
  logic          direct;
  logic          arr_wr;

  always_comb begin
    in_ready = init_reg && (level_reg != FULL_LEVEL);
    wr       = in_valid && in_ready;
    rd       = out_valid_reg && out_ready;
`ifdef DUT_IN_FIFO_BYPASS_EN
    // Bypass only when nothing is stored, so ordering cannot be violated.
    out_valid = out_valid_reg;
    out_data  = out_data_reg;
    store     = wr;
    if (!flush && wr && (level_reg == '0)) begin
      out_valid = 1'b1;
      out_data  = in_data;
      // Word consumed straight through: it never enters the buffer.
      store     = !out_ready;
    end
`else
    out_valid = out_valid_reg;
    out_data  = out_data_reg;
    store     = wr;
`endif
    // Words sitting in the array, excluding the output register.
    arr_count  = level_reg - (AW+1)'(out_valid_reg);
    reg_load   = !out_valid_reg || rd;
    from_arr   = reg_load && (arr_count != '0);
    // With the array empty, a fresh word skips the array and lands in the
    // output register directly, giving the one-cycle latency.
    direct     = reg_load && (arr_count == '0) && store;
    arr_wr     = store && !direct;
    level_next = level_reg + (AW+1)'(store) - (AW+1)'(rd);
    level      = level_reg;
    hwm        = hwm_reg;
  end

  // Array storage: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (arr_wr && !flush) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      hwm_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      init_reg      <= 1'b0;
    end else begin
      init_reg <= 1'b1;
      if (flush) begin
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        level_reg     <= '0;
        hwm_reg       <= '0;
        out_valid_reg <= 1'b0;
      end else begin
        if (arr_wr) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (from_arr) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
        if (reg_load) begin
          if (from_arr) begin
            out_data_reg  <= mem[rd_ptr_reg];
            out_valid_reg <= 1'b1;
          end else if (direct) begin
            out_data_reg  <= in_data;
            out_valid_reg <= 1'b1;
          end else begin
            out_valid_reg <= 1'b0;
          end
        end
        level_reg <= level_next;
        if (level_next > hwm_reg) begin
          hwm_reg <= level_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_dut_in_fifo.sv
module tb_dut_in_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW:0]   level;
  logic [AW:0]   hwm;

  dut_in_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level), .hwm(hwm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of stored words plus a high-water mark.
  logic [DW-1:0] mq[$];
  int            m_hwm = 0;
  bit            m_init = 1'b0;

  // Upstream must hold in_data while stalled.
  logic [DW-1:0] prev_data;
  bit            prev_stall = 1'b0;
  always @(posedge clk) begin
    if (rst_n && prev_stall && in_valid)
      assert (in_data == prev_data) else $error("upstream changed in_data while stalled");
    prev_stall <= in_valid && !in_ready;
    prev_data  <= in_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return m_init && (mq.size() != DEPTH);
  endfunction

  function automatic bit m_byp();
`ifdef DUT_IN_FIFO_BYPASS_EN
    return !flush && in_valid && m_ready() && (mq.size() == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ov();
    return (mq.size() > 0) || m_byp();
  endfunction

  function automatic logic [DW-1:0] m_od();
    return m_byp() ? in_data : mq[0];
  endfunction

  task automatic drive(input bit f, input bit iv, input logic [DW-1:0] id, input bit ordy);
    flush = f; in_valid = iv; in_data = id; out_ready = ordy;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_ready()));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov()));
    if (m_ov()) chk({tag, ".out_data"}, 32'(out_data), 32'(m_od()));
    chk({tag, ".level"}, 32'(level), 32'(mq.size()));
    chk({tag, ".hwm"}, 32'(hwm), 32'(m_hwm));
  endtask

  // Advance the model by one clock using the inputs currently applied, then clock.
  task automatic tick();
    bit wr, rd, pass;
    if (!rst_n) begin
      mq.delete(); m_hwm = 0; m_init = 1'b0;
    end else if (flush) begin
      mq.delete(); m_hwm = 0; m_init = 1'b1;
    end else begin
      pass = m_byp() && out_ready;
      wr   = in_valid && m_ready() && !pass;
      rd   = (mq.size() > 0) && out_ready;
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(in_data);
      if (mq.size() > m_hwm) m_hwm = mq.size();
      m_init = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit            fl;
    bit            iv;
    logic [DW-1:0] id;
    bit            ordy;
    bit            e_ir;
    bit            e_ov;
    logic [DW-1:0] e_od;
    int            e_lvl;
    int            e_hwm;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit iv, logic [DW-1:0] id, bit ordy,
                              bit e_ir, bit e_ov, logic [DW-1:0] e_od, int e_lvl, int e_hwm);
    vec_t v;
    v.fl = 1'b0; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_lvl = e_lvl; v.e_hwm = e_hwm;
    vt.push_back(v);
  endfunction

  logic [DW-1:0] recv[$];
  int            max_lvl;
  int            sent;
  bit            hold;

  initial begin
    // Reset then single word, fill, full-with-read, drain.
    add(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0);
    add(1, 16'hFF89, 1, 1, 0, 16'h0000, 0, 0);
    add(0, 16'h0000, 1, 1, 1, 16'hFF89, 1, 1);
    add(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1);
    for (int i = 0; i < 16; i++)
      add(1, 16'(i), 0, 1, i > 0, 16'h0000, i, (i > 1) ? i : 1);
    add(1, 16'h0010, 0, 0, 1, 16'h0000, 16, 16);
    add(1, 16'h0010, 0, 0, 1, 16'h0000, 16, 16);
    add(1, 16'h0010, 1, 0, 1, 16'h0000, 16, 16);
    add(0, 16'h0000, 0, 1, 1, 16'h0001, 15, 16);
    for (int k = 0; k < 15; k++)
      add(0, 16'h0000, 1, 1, 1, 16'(k + 1), 15 - k, 16);
    add(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 0);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_data", 32'(out_data), 0);
    chk("rst.level", 32'(level), 0);
    chk("rst.hwm", 32'(hwm), 0);
    rst_n = 1'b1;

`ifndef DUT_IN_FIFO_BYPASS_EN
    foreach (vt[i]) begin
      drive(vt[i].fl, vt[i].iv, vt[i].id, vt[i].ordy);
      #1;
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      if (vt[i].e_ov) chk($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(vt[i].e_od));
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(vt[i].e_lvl));
      chk($sformatf("vec%0d.hwm", i), 32'(hwm), 32'(vt[i].e_hwm));
      $display("vec %0d iv=%0d id=%h ordy=%0d -> ir=%0d ov=%0d od=%h lvl=%0d hwm=%0d",
               i, vt[i].iv, vt[i].id, vt[i].ordy, in_ready, out_valid, out_data, level, hwm);
      tick();
    end
`else
    foreach (vt[i]) begin
      drive(vt[i].fl, vt[i].iv, vt[i].id, vt[i].ordy);
      #1;
      check_model($sformatf("vec%0d", i));
      tick();
    end
`endif

    // Wrap and simultaneous traffic: 40 words, out_ready pattern 1,1,0.
    recv.delete(); sent = 0; max_lvl = 0;
    for (int c = 0; c < 400 && recv.size() < 40; c++) begin
      drive(0, sent < 40, 16'(16'h0089 + sent), (c % 3) != 2);
      #1;
      check_model("wrap");
      if (out_valid && out_ready) recv.push_back(out_data);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (in_valid && m_ready()) sent++;
      tick();
    end
    chk("wrap.count", 32'(recv.size()), 40);
    for (int i = 0; i < recv.size(); i++)
      chk($sformatf("wrap.word%0d", i), 32'(recv[i]), 32'(16'h0089 + i));
    chk("wrap.max_level_le_16", 32'(max_lvl <= 16), 1);
    $display("wrap: received %0d words, max level %0d", recv.size(), max_lvl);

    // Flush at level 7 alongside a write.
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 16'(16'h00A0 + i), 0);
      #1; check_model("pre_flush"); tick();
    end
    drive(1, 1, 16'hDEAD, 1);
    #1; check_model("flush_cycle"); tick();
    drive(0, 0, 16'h0000, 1);
    #1;
    chk("flush.level", 32'(level), 0);
    chk("flush.hwm", 32'(hwm), 0);
    chk("flush.out_valid", 32'(out_valid), 0);
    $display("flush: level=%0d hwm=%0d out_valid=%0d", level, hwm, out_valid);
    for (int i = 0; i < 4; i++) begin
      #1; chk("flush.no_word", 32'(out_valid), 0); tick();
    end

`ifdef DUT_IN_FIFO_BYPASS_EN
    drive(0, 1, 16'h1234, 1);
    #1;
    chk("byp.out_valid", 32'(out_valid), 1);
    chk("byp.out_data", 32'(out_data), 32'h1234);
    chk("byp.level", 32'(level), 0);
    $display("bypass: ov=%0d od=%h lvl=%0d", out_valid, out_data, level);
    tick();
    drive(0, 0, 16'h0000, 0);
    #1;
    chk("byp.level_after", 32'(level), 0);
    chk("byp.out_valid_after", 32'(out_valid), 0);
    tick();
`endif

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 16'(16'h00C0 + i), 0);
      #1; check_model("pre_reset"); tick();
    end
    drive(0, 0, 16'h0000, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 0);
    chk("arst.out_data", 32'(out_data), 0);
    chk("arst.level", 32'(level), 0);
    chk("arst.hwm", 32'(hwm), 0);
    chk("arst.in_ready", 32'(in_ready), 0);
    $display("async reset: ov=%0d lvl=%0d hwm=%0d ir=%0d", out_valid, level, hwm, in_ready);
    mq.delete(); m_hwm = 0; m_init = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1; check_model("post_reset"); tick();

    // Randomized traffic with phases biased toward full and toward empty.
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit iv;
      logic [DW-1:0] id;
      if (hold) begin
        iv = in_valid; id = in_data;
      end else begin
        iv = ($urandom % 4) != 0;
        id = 16'($urandom);
      end
      drive(($urandom % 50) == 0, iv, id,
            ((c / 100) % 2 == 0) ? (($urandom % 10) < 3) : (($urandom % 10) < 8));
      #1;
      check_model("rand");
      hold = in_valid && !m_ready();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
